frame_renderer: RTL and testbench

Pixel-colour stage directly downstream of the game logic. Snapshots the game state (paddle, ball, 72-bit block map) once per frame, paces the game logic with a `START_UPDATE` pulse during vertical blanking, and turns the VGA timing generator's pixel coordinates into an 8-bit RGB332 colour through a fixed 2-stage pipeline. Snapshotting keeps mid-frame game updates from tearing the displayed image.

---
 rtl/frame_renderer_if.sv | 28 ++
 rtl/frame_renderer.sv | 160 ++++++++++++++++
 tb/tb_frame_renderer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/frame_renderer_if.sv
// Pixel-stream and game-state bundle between the VGA timing/game logic and frame_renderer.
// The master drives pixel coordinates and live game state; the slave (renderer) returns colour and pacing.
interface frame_renderer_if;
   logic [9:0]  PIXEL_X;
   logic [9:0]  PIXEL_Y;
   logic        PIXEL_VALID;
   logic        VBLANK_START;
   logic        FRAME_START;
   logic [9:0]  PADDLE_X_PIXEL;
   logic [9:0]  BALL_X_PIXEL;
   logic [9:0]  BALL_Y_PIXEL;
   logic [71:0] BLOCK_STATE;
   logic        START_UPDATE;
   logic [7:0]  RGB;
   logic        RGB_VALID;

   modport master (
      output PIXEL_X, PIXEL_Y, PIXEL_VALID, VBLANK_START, FRAME_START,
             PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL, BLOCK_STATE,
      input  START_UPDATE, RGB, RGB_VALID
   );

   modport slave (
      input  PIXEL_X, PIXEL_Y, PIXEL_VALID, VBLANK_START, FRAME_START,
             PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL, BLOCK_STATE,
      output START_UPDATE, RGB, RGB_VALID
   );
endinterface

// File: rtl/frame_renderer.sv
// Per-frame snapshot of game state plus a fixed 2-stage pixel-to-RGB332 pipeline.
// Also emits the one-cycle START_UPDATE pulse that paces the game logic.
module frame_renderer #(
   parameter int unsigned BLOCK_START_X    = 16,
   parameter int unsigned BLOCK_START_Y    = 64,
   parameter int unsigned BLOCK_COLS       = 12,
   parameter int unsigned BLOCK_ROWS       = 6,
   parameter int unsigned WALL_LEFT_END    = 16,
   parameter int unsigned WALL_RIGHT_BEGIN = 784,
   parameter int unsigned CEILING_END      = 16,
   parameter int unsigned PADDLE_Y         = 560,
   parameter int unsigned BALL_SIZE        = 8
) (
   input  logic            CLK,
   input  logic            RST_N,
   frame_renderer_if.slave bus
);

   localparam logic [10:0] BLK_X0  = 11'(BLOCK_START_X);
   localparam logic [10:0] BLK_X1  = 11'(BLOCK_START_X + BLOCK_COLS * 64);
   localparam logic [10:0] BLK_Y0  = 11'(BLOCK_START_Y);
   localparam logic [10:0] BLK_Y1  = 11'(BLOCK_START_Y + BLOCK_ROWS * 16);
   localparam logic [10:0] WALL_L  = 11'(WALL_LEFT_END);
   localparam logic [10:0] WALL_R  = 11'(WALL_RIGHT_BEGIN);
   localparam logic [10:0] CEIL    = 11'(CEILING_END);
   localparam logic [10:0] PAD_Y0  = 11'(PADDLE_Y);
   localparam logic [10:0] PAD_Y1  = 11'(PADDLE_Y + 8);
   localparam logic [10:0] PAD_W   = 11'd64;
   localparam logic [10:0] BALL_W  = 11'(BALL_SIZE);
   localparam logic [6:0]  N_BLOCK = 7'(BLOCK_COLS * BLOCK_ROWS);

   function automatic logic [7:0] rowColour(input logic [2:0] row);
      case (row)
         3'd0:    rowColour = 8'hE0;
         3'd1:    rowColour = 8'hF0;
         3'd2:    rowColour = 8'hFC;
         3'd3:    rowColour = 8'h1C;
         3'd4:    rowColour = 8'h1F;
         3'd5:    rowColour = 8'h03;
         default: rowColour = 8'h00;
      endcase
   endfunction

   logic [9:0]  shadowPadX, shadowBallX, shadowBallY;
   logic [71:0] shadowBlocks;
   logic        snapValid;

   // A pixel presented with FRAME_START already sees the incoming snapshot.
   logic [10:0] padX, ballX, ballY, pixX, pixY;
   logic [9:0]  relX;
   logic [6:0]  relY;
   assign padX  = {1'b0, (bus.FRAME_START ? bus.PADDLE_X_PIXEL : shadowPadX)};
   assign ballX = {1'b0, (bus.FRAME_START ? bus.BALL_X_PIXEL   : shadowBallX)};
   assign ballY = {1'b0, (bus.FRAME_START ? bus.BALL_Y_PIXEL   : shadowBallY)};
   assign pixX  = {1'b0, bus.PIXEL_X};
   assign pixY  = {1'b0, bus.PIXEL_Y};
   assign relX  = 10'(pixX - BLK_X0);
   assign relY  = 7'(pixY - BLK_Y0);

   logic inBlocksS, groutS, ballS, paddleS, wallS;
   assign inBlocksS = (pixX >= BLK_X0) && (pixX < BLK_X1) && (pixY >= BLK_Y0) && (pixY < BLK_Y1);
   assign groutS    = (relX[5:0] == 6'd0) || (relY[3:0] == 4'd0);
   assign ballS     = (pixX >= ballX) && (pixX < ballX + BALL_W) &&
                      (pixY >= ballY) && (pixY < ballY + BALL_W);
   assign paddleS   = (pixX >= padX) && (pixX < padX + PAD_W) && (pixY >= PAD_Y0) && (pixY < PAD_Y1);
   assign wallS     = (pixX < WALL_L) || (pixX >= WALL_R) || (pixY < CEIL);

   logic       validD1, inBlocksD1, groutD1, ballD1, paddleD1, wallD1;
   logic [3:0] colD1;
   logic [2:0] rowD1;

   // Pacing pulse and frame snapshot.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bus.START_UPDATE <= 1'b0;
         shadowPadX       <= 10'd0;
         shadowBallX      <= 10'd0;
         shadowBallY      <= 10'd0;
         shadowBlocks     <= 72'd0;
         snapValid        <= 1'b0;
      end else begin
         bus.START_UPDATE <= bus.VBLANK_START;
         if (bus.FRAME_START) begin
            shadowPadX   <= bus.PADDLE_X_PIXEL;
            shadowBallX  <= bus.BALL_X_PIXEL;
            shadowBallY  <= bus.BALL_Y_PIXEL;
            shadowBlocks <= bus.BLOCK_STATE;
            snapValid    <= 1'b1;
         end
      end
   end

   // Stage 1: geometric classification of the pixel.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         validD1    <= 1'b0;
         inBlocksD1 <= 1'b0;
         groutD1    <= 1'b0;
         ballD1     <= 1'b0;
         paddleD1   <= 1'b0;
         wallD1     <= 1'b0;
         colD1      <= 4'd0;
         rowD1      <= 3'd0;
      end else begin
         validD1    <= bus.PIXEL_VALID;
         inBlocksD1 <= inBlocksS;
         groutD1    <= groutS;
         ballD1     <= ballS;
         paddleD1   <= paddleS;
         wallD1     <= wallS;
         colD1      <= relX[9:6];
         rowD1      <= relY[6:4];
      end
   end

   logic [6:0] blockIdx;
   logic       blockPresent;
   logic [7:0] nextRgb;
   assign blockIdx = ({4'd0, rowD1} * 7'd12) + {3'd0, colD1};

   // Block-map lookup, guarded against indices outside the map.
   always_comb begin
      blockPresent = 1'b0;
      if (inBlocksD1 && (blockIdx < N_BLOCK)) begin
         blockPresent = shadowBlocks[blockIdx];
      end else begin
         blockPresent = 1'b0;
      end
   end

   // Colour priority resolution.
   always_comb begin
      nextRgb = 8'h00;
      if (!validD1 || !snapValid) begin
         nextRgb = 8'h00;
      end else if (ballD1) begin
         nextRgb = 8'hFF;
      end else if (paddleD1) begin
         nextRgb = 8'hDB;
      end else if (blockPresent && !groutD1) begin
         nextRgb = rowColour(rowD1);
      end else if (wallD1) begin
         nextRgb = 8'h92;
      end else begin
         nextRgb = 8'h00;
      end
   end

   // Stage 2: registered colour output.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bus.RGB       <= 8'h00;
         bus.RGB_VALID <= 1'b0;
      end else begin
         bus.RGB       <= nextRgb;
         bus.RGB_VALID <= validD1;
      end
   end

endmodule

// File: tb/tb_frame_renderer.sv
// Self-checking bench for frame_renderer: vector table through a latency-aware scoreboard,
// plus hand-written reset, pacing and mid-frame reset sequences.
module tb_frame_renderer;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   frame_renderer_if bus ();

   frame_renderer dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // Cycle counter, read by the driver #1 after each rising edge.
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      string       name;
      logic [9:0]  pad, bx, by;
      logic [71:0] blk;
      logic        fs, vb;
      logic [9:0]  x, y;
      logic        vld;
      logic [7:0]  rgb;
   } vec_t;

   typedef struct {
      int          due;
      logic [7:0]  rgb;
      logic        vld;
      logic        su;
      string       name;
   } exp_t;

   exp_t pixQ[$];
   exp_t startQ[$];

   function automatic vec_t mk(input string n, input logic [9:0] pad, input logic [9:0] bx,
                               input logic [9:0] by, input logic [71:0] blk, input logic fs,
                               input logic vb, input logic [9:0] x, input logic [9:0] y,
                               input logic vld, input logic [7:0] rgb);
      vec_t v;
      v.name = n; v.pad = pad; v.bx = bx; v.by = by; v.blk = blk;
      v.fs = fs; v.vb = vb; v.x = x; v.y = y; v.vld = vld; v.rgb = rgb;
      return v;
   endfunction

   // Scoreboard: compare outputs when each expectation falls due.
   always @(negedge CLK) begin
      exp_t e;
      if (pixQ.size() > 0 && pixQ[0].due <= cyc) begin
         e = pixQ.pop_front();
         tests++;
         if (e.due != cyc || bus.RGB !== e.rgb || bus.RGB_VALID !== e.vld) begin
            fails++;
            $display("FAIL %s cyc=%0d: got rgb=%02h valid=%b, want rgb=%02h valid=%b (due %0d)",
                     e.name, cyc, bus.RGB, bus.RGB_VALID, e.rgb, e.vld, e.due);
         end
      end
      if (startQ.size() > 0 && startQ[0].due <= cyc) begin
         e = startQ.pop_front();
         tests++;
         if (e.due != cyc || bus.START_UPDATE !== e.su) begin
            fails++;
            $display("FAIL %s.start cyc=%0d: got START_UPDATE=%b, want %b",
                     e.name, cyc, bus.START_UPDATE, e.su);
         end
      end
   end

   task automatic drive(input vec_t v);
      @(posedge CLK);
      #1;
      bus.PADDLE_X_PIXEL = v.pad;
      bus.BALL_X_PIXEL   = v.bx;
      bus.BALL_Y_PIXEL   = v.by;
      bus.BLOCK_STATE    = v.blk;
      bus.FRAME_START    = v.fs;
      bus.VBLANK_START   = v.vb;
      bus.PIXEL_X        = v.x;
      bus.PIXEL_Y        = v.y;
      bus.PIXEL_VALID    = v.vld;
      pixQ.push_back('{due: cyc + 2, rgb: v.rgb, vld: v.vld, su: 1'b0, name: v.name});
      startQ.push_back('{due: cyc + 1, rgb: 8'h00, vld: 1'b0, su: v.vb, name: v.name});
   endtask

   task automatic resetStep(input logic r);
      @(posedge CLK);
      #1;
      RST_N            = r;
      bus.PIXEL_VALID  = 1'b0;
      bus.FRAME_START  = 1'b0;
      bus.VBLANK_START = 1'b0;
      if (!r) begin
         pixQ.delete();
         startQ.delete();
         pixQ.push_back('{due: cyc, rgb: 8'h00, vld: 1'b0, su: 1'b0, name: "rstRgb"});
         startQ.push_back('{due: cyc, rgb: 8'h00, vld: 1'b0, su: 1'b0, name: "rstStart"});
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[$];
      vec_t        idle;
      logic [71:0] allB;
      logic [71:0] no13;

      allB = {72{1'b1}};
      no13 = allB;
      no13[13] = 1'b0;
      idle = mk("idle", 10'd0, 10'd0, 10'd0, 72'd0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 8'h00);

      tbl.push_back(mk("blkR0",     10'd300, 10'd500, 10'd400, allB, 1'b1, 1'b0, 10'd17,   10'd65,  1'b1, 8'hE0));
      tbl.push_back(mk("grout",     10'd300, 10'd500, 10'd400, allB, 1'b0, 1'b0, 10'd16,   10'd65,  1'b1, 8'h00));
      tbl.push_back(mk("blkR5",     10'd300, 10'd500, 10'd400, allB, 1'b0, 1'b0, 10'd100,  10'd150, 1'b1, 8'h03));
      tbl.push_back(mk("blkR1",     10'd300, 10'd500, 10'd400, allB, 1'b0, 1'b0, 10'd100,  10'd81,  1'b1, 8'hF0));
      tbl.push_back(mk("blkR2",     10'd300, 10'd500, 10'd400, allB, 1'b0, 1'b0, 10'd100,  10'd100, 1'b1, 8'hFC));
      tbl.push_back(mk("blkR3",     10'd300, 10'd500, 10'd400, allB, 1'b0, 1'b0, 10'd100,  10'd120, 1'b1, 8'h1C));
      tbl.push_back(mk("blkR4",     10'd300, 10'd500, 10'd400, allB, 1'b0, 1'b0, 10'd100,  10'd136, 1'b1, 8'h1F));
      tbl.push_back(mk("invalid",   10'd300, 10'd500, 10'd400, allB, 1'b0, 1'b0, 10'd17,   10'd65,  1'b0, 8'h00));
      tbl.push_back(mk("blkEdgeR",  10'd300, 10'd500, 10'd400, allB, 1'b0, 1'b0, 10'd783,  10'd65,  1'b1, 8'hE0));
      tbl.push_back(mk("wallR",     10'd300, 10'd500, 10'd400, allB, 1'b0, 1'b0, 10'd784,  10'd65,  1'b1, 8'h92));
      tbl.push_back(mk("blkBot",    10'd300, 10'd500, 10'd400, allB, 1'b0, 1'b0, 10'd17,   10'd159, 1'b1, 8'h03));
      tbl.push_back(mk("belowBlk",  10'd300, 10'd500, 10'd400, allB, 1'b0, 1'b0, 10'd17,   10'd160, 1'b1, 8'h00));
      tbl.push_back(mk("clr13",     10'd300, 10'd500, 10'd400, no13, 1'b1, 1'b0, 10'd81,   10'd81,  1'b1, 8'h00));
      tbl.push_back(mk("col2",      10'd300, 10'd500, 10'd400, no13, 1'b0, 1'b0, 10'd145,  10'd81,  1'b1, 8'hF0));
      tbl.push_back(mk("ballHit",   10'd300, 10'd20,  10'd70,  allB, 1'b1, 1'b0, 10'd20,   10'd70,  1'b1, 8'hFF));
      tbl.push_back(mk("ballEdgeX", 10'd300, 10'd20,  10'd70,  allB, 1'b0, 1'b0, 10'd28,   10'd70,  1'b1, 8'hE0));
      tbl.push_back(mk("ballCorner",10'd300, 10'd20,  10'd70,  allB, 1'b0, 1'b0, 10'd27,   10'd77,  1'b1, 8'hFF));
      tbl.push_back(mk("wallL",     10'd300, 10'd20,  10'd70,  allB, 1'b0, 1'b0, 10'd10,   10'd70,  1'b1, 8'h92));
      tbl.push_back(mk("ballBelow", 10'd300, 10'd20,  10'd70,  allB, 1'b0, 1'b0, 10'd20,   10'd78,  1'b1, 8'hE0));
      tbl.push_back(mk("ballSnap",  10'd300, 10'd300, 10'd300, allB, 1'b1, 1'b0, 10'd300,  10'd300, 1'b1, 8'hFF));
      tbl.push_back(mk("isoOld",    10'd300, 10'd500, 10'd300, allB, 1'b0, 1'b0, 10'd300,  10'd300, 1'b1, 8'hFF));
      tbl.push_back(mk("isoNotYet", 10'd300, 10'd500, 10'd300, allB, 1'b0, 1'b0, 10'd500,  10'd300, 1'b1, 8'h00));
      tbl.push_back(mk("isoNewFS",  10'd300, 10'd500, 10'd300, allB, 1'b1, 1'b0, 10'd500,  10'd300, 1'b1, 8'hFF));
      tbl.push_back(mk("isoOldGone",10'd300, 10'd500, 10'd300, allB, 1'b0, 1'b0, 10'd300,  10'd300, 1'b1, 8'h00));
      tbl.push_back(mk("pad1",      10'd300, 10'd500, 10'd300, allB, 1'b0, 1'b0, 10'd310,  10'd562, 1'b1, 8'hDB));
      tbl.push_back(mk("pad0",      10'd300, 10'd500, 10'd300, allB, 1'b0, 1'b0, 10'd310,  10'd562, 1'b0, 8'h00));
      tbl.push_back(mk("pad1b",     10'd300, 10'd500, 10'd300, allB, 1'b0, 1'b0, 10'd310,  10'd562, 1'b1, 8'hDB));
      tbl.push_back(mk("ballWrap",  10'd720, 10'd1020,10'd300, allB, 1'b1, 1'b0, 10'd4,    10'd300, 1'b1, 8'h92));
      tbl.push_back(mk("ballRWall", 10'd720, 10'd1020,10'd300, allB, 1'b0, 1'b0, 10'd1020, 10'd300, 1'b1, 8'hFF));
      tbl.push_back(mk("padR",      10'd720, 10'd1020,10'd300, allB, 1'b0, 1'b0, 10'd783,  10'd560, 1'b1, 8'hDB));
      tbl.push_back(mk("padWall",   10'd720, 10'd1020,10'd300, allB, 1'b0, 1'b0, 10'd784,  10'd560, 1'b1, 8'h92));
      tbl.push_back(mk("padBot",    10'd720, 10'd1020,10'd300, allB, 1'b0, 1'b0, 10'd720,  10'd567, 1'b1, 8'hDB));
      tbl.push_back(mk("padBelow",  10'd720, 10'd1020,10'd300, allB, 1'b0, 1'b0, 10'd720,  10'd568, 1'b1, 8'h00));
      tbl.push_back(mk("padLeft",   10'd720, 10'd1020,10'd300, allB, 1'b0, 1'b0, 10'd719,  10'd560, 1'b1, 8'h00));
      tbl.push_back(mk("ceil",      10'd720, 10'd1020,10'd300, allB, 1'b0, 1'b0, 10'd400,  10'd15,  1'b1, 8'h92));
      tbl.push_back(mk("ceilEnd",   10'd720, 10'd1020,10'd300, allB, 1'b0, 1'b0, 10'd400,  10'd16,  1'b1, 8'h00));

      bus.PIXEL_X = 10'd0; bus.PIXEL_Y = 10'd0; bus.PIXEL_VALID = 1'b0;
      bus.VBLANK_START = 1'b0; bus.FRAME_START = 1'b0;
      bus.PADDLE_X_PIXEL = 10'd0; bus.BALL_X_PIXEL = 10'd0; bus.BALL_Y_PIXEL = 10'd0;
      bus.BLOCK_STATE = 72'd0;

      // Reset state, then pacing with black output before any snapshot.
      for (int i = 0; i < 3; i++) resetStep(1'b0);
      resetStep(1'b1);
      for (int i = 0; i < 10; i++)
         drive(mk("preSnap", 10'd0, 10'd500, 10'd400, allB, 1'b0, 1'b0, 10'd10, 10'd562, 1'b1, 8'h00));
      drive(mk("vblank", 10'd0, 10'd500, 10'd400, allB, 1'b0, 1'b1, 10'd10, 10'd562, 1'b1, 8'h00));
      drive(idle);
      drive(idle);
      drive(mk("vbB2B0", 10'd0, 10'd500, 10'd400, allB, 1'b0, 1'b1, 10'd0, 10'd0, 1'b0, 8'h00));
      drive(mk("vbB2B1", 10'd0, 10'd500, 10'd400, allB, 1'b0, 1'b1, 10'd0, 10'd0, 1'b0, 8'h00));
      drive(idle);
      drive(mk("vbAndFs", 10'd300, 10'd500, 10'd400, allB, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 8'h00));
      drive(idle);

      for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);
      for (int i = 0; i < 3; i++) drive(idle);

      // Mid-frame reset discards the in-flight paddle pixel and the snapshot.
      drive(mk("preRst", 10'd720, 10'd1020, 10'd300, allB, 1'b0, 1'b0, 10'd730, 10'd562, 1'b1, 8'hDB));
      resetStep(1'b0);
      resetStep(1'b0);
      resetStep(1'b1);
      drive(mk("postRst", 10'd720, 10'd1020, 10'd300, allB, 1'b0, 1'b0, 10'd730, 10'd562, 1'b1, 8'h00));
      drive(mk("postRst2", 10'd720, 10'd1020, 10'd300, allB, 1'b0, 1'b0, 10'd730, 10'd562, 1'b1, 8'h00));
      drive(mk("postRstFs", 10'd720, 10'd1020, 10'd300, allB, 1'b1, 1'b0, 10'd730, 10'd562, 1'b1, 8'hDB));
      for (int i = 0; i < 4; i++) drive(idle);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
